// File: rtl/key_pkg.sv
// Shared types and default timing constants for the push-button front-end.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } key_state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int unsigned CNT_W_DEF           = 20;
    localparam int unsigned REPEAT_DELAY_DEF    = 50000000;
    localparam int unsigned REPEAT_PERIOD_DEF   = 10000000;

endpackage

// File: rtl/key_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM and counter.
// Auto-repeat in HELD is built only when KEY_AUTOREPEAT_EN is defined.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic key_pulse,
    output logic key_pulse_nxt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic             key_sync;

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REPEAT_DELAY - 1);
    // Reload so the next compare hit lands REPEAT_PERIOD cycles later.
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [REP_W-1:0] rep_q, rep_d;
`endif

    assign key_sync = sync_q[1];

    always_comb begin
        sync_d  = {sync_q[0], key_in};
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rep_d   = rep_q;
`endif
        case (state_q)
            IDLE: begin
                if (key_sync) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!key_sync) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!key_sync) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = '0;
                end
`ifdef KEY_AUTOREPEAT_EN
                else if (rep_q == REP_LAST) begin
                    pulse_d = 1'b1;
                    rep_d   = REP_RELOAD;
                end else begin
                    rep_d = rep_q + REP_W'(1);
                end
`endif
            end
            RELEASE_CHK: begin
                if (key_sync) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    level_d = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
                    rep_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
`ifdef KEY_AUTOREPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    assign key_level     = level_q;
    assign key_pulse     = pulse_q;
    assign key_pulse_nxt = pulse_d;

endmodule

// File: rtl/key_pulse_gen.sv
// N-key debounced pulse generator with an OR-ed pulse for the mode counter.
// Optional auto-repeat via KEY_AUTOREPEAT_EN.
module key_pulse_gen
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS          = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_pulse,
    output logic              any_pulse
);

    logic [N_KEYS-1:0] pulse_nxt;
    logic              any_pulse_q, any_pulse_d;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
`ifdef KEY_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .key_in        (key_in[i]),
            .key_level     (key_level[i]),
            .key_pulse     (key_pulse[i]),
            .key_pulse_nxt (pulse_nxt[i])
        );
    end

`ifndef KEY_AUTOREPEAT_EN
    // Repeat timing has no effect in this build; kept so instantiations stay portable.
    if (REPEAT_DELAY < REPEAT_PERIOD) begin : g_repeat_ignored
    end
`endif

    // OR of the channels' next-pulse keeps any_pulse aligned with key_pulse.
    always_comb begin
        any_pulse_d = |pulse_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_pulse_q <= 1'b0;
        end else begin
            any_pulse_q <= any_pulse_d;
        end
    end

    assign any_pulse = any_pulse_q;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Scoreboard bench for key_pulse_gen (DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5).
// Expectations follow KEY_AUTOREPEAT_EN when the macro is defined.
module tb_key_pulse_gen;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  vec;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] key_in;
    logic [1:0] key_level;
    logic [1:0] key_pulse;
    logic       any_pulse;

    int unsigned cyc = 0;
    bit          done = 1'b0;
    exp_t        pulse_q[$];
    exp_t        level_q[$];

    key_pulse_gen #(
        .N_KEYS          (2),
        .DEBOUNCE_CYCLES (8),
        .CNT_W           (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_level (key_level),
        .key_pulse (key_pulse),
        .any_pulse (any_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_pulse(input int unsigned at, input logic [1:0] v);
        exp_t e;
        e.cyc = at;
        e.vec = v;
        pulse_q.push_back(e);
    endtask

    task automatic exp_level(input int unsigned at, input logic [1:0] v);
        exp_t e;
        e.cyc = at;
        e.vec = v;
        level_q.push_back(e);
    endtask

    // Stimulus: directed presses; every expected event is pushed when issued.
    initial begin
        int unsigned c;
        int unsigned r;
        rst_n  = 1'b0;
        key_in = 2'b11;
        tick(5);

        // Reset release with both keys held
        c = cyc;
        rst_n = 1'b1;
        exp_level(c + 10, 2'b00);
        exp_pulse(c + 11, 2'b11);
        exp_level(c + 11, 2'b11);
        tick(11);
        c = cyc;
        key_in = 2'b00;
        exp_level(c + 10, 2'b11);
        exp_level(c + 11, 2'b00);
        tick(14);

        // Clean press on key 0 with a short release bounce while held
        c = cyc;
        key_in = 2'b01;
        exp_level(c + 10, 2'b00);
        exp_pulse(c + 11, 2'b01);
        exp_level(c + 11, 2'b01);
        tick(15);
        key_in = 2'b00;
        tick(2);
        key_in = 2'b01;
        exp_level(c + 19, 2'b01);
        tick(3);
        key_in = 2'b00;
        exp_level(c + 30, 2'b01);
        exp_level(c + 31, 2'b00);
        tick(14);

        // Press bounce: 1,0,1,0 every 3 cycles then steady 1
        c = cyc;
        key_in = 2'b01;
        exp_level(c + 22, 2'b00);
        exp_pulse(c + 23, 2'b01);
        exp_level(c + 23, 2'b01);
        tick(3); key_in = 2'b00;
        tick(3); key_in = 2'b01;
        tick(3); key_in = 2'b00;
        tick(3); key_in = 2'b01;
        tick(16);
        key_in = 2'b00;
        exp_level(c + 38, 2'b01);
        exp_level(c + 39, 2'b00);
        tick(14);

        // Simultaneous press: one shared any_pulse cycle
        c = cyc;
        key_in = 2'b11;
        exp_pulse(c + 11, 2'b11);
        exp_level(c + 11, 2'b11);
        tick(15);
        key_in = 2'b00;
        tick(15);

        // Staggered presses stay independent
        c = cyc;
        key_in = 2'b01;
        tick(3);
        key_in = 2'b11;
        exp_pulse(c + 11, 2'b01);
        exp_level(c + 12, 2'b01);
        exp_pulse(c + 14, 2'b10);
        exp_level(c + 14, 2'b11);
        tick(15);
        key_in = 2'b00;
        tick(15);

        // Reset inside PRESS_CHK, then inside HELD, key held throughout
        c = cyc;
        key_in = 2'b01;
        tick(8);
        rst_n = 1'b0;
        tick(2);
        r = cyc;
        rst_n = 1'b1;
        exp_level(r + 10, 2'b00);
        exp_pulse(r + 11, 2'b01);
        exp_level(r + 11, 2'b01);
        tick(12);
        rst_n = 1'b0;
        tick(2);
        r = cyc;
        rst_n = 1'b1;
        exp_pulse(r + 11, 2'b01);
        exp_level(r + 11, 2'b01);
        tick(13);
        key_in = 2'b00;
        exp_level(cyc + 11, 2'b00);
        tick(14);

        // Long hold: repeats only when auto-repeat is built in
        c = cyc;
        key_in = 2'b01;
        exp_pulse(c + 11, 2'b01);
`ifdef KEY_AUTOREPEAT_EN
        for (int k = 0; k < 7; k++) exp_pulse(c + 31 + 5 * k, 2'b01);
`endif
        tick(61);
        key_in = 2'b00;
        exp_level(c + 71, 2'b01);
        exp_level(c + 72, 2'b00);
        tick(15);

        done = 1'b1;
    end

    // Monitor: pops the scoreboards whenever the DUT shows a pulse or a level check is due.
    initial begin
        int unsigned n_cmp;
        int unsigned n_err;
        exp_t        e;
        n_cmp = 0;
        n_err = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                n_cmp++;
                if ({key_level, key_pulse, any_pulse} !== 5'b0) begin
                    n_err++;
                    $display("FAIL reset_outputs cycle %0d: got %b required 00000",
                             cyc, {key_level, key_pulse, any_pulse});
                end
            end else if (key_pulse !== 2'b00 || any_pulse !== 1'b0) begin
                if (pulse_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pulse cycle %0d: key_pulse=%b any_pulse=%b required none",
                             cyc, key_pulse, any_pulse);
                end else begin
                    e = pulse_q.pop_front();
                    n_cmp++;
                    if (e.cyc != cyc) begin
                        n_err++;
                        $display("FAIL pulse_cycle: got cycle %0d required cycle %0d", cyc, e.cyc);
                    end
                    n_cmp++;
                    if (key_pulse !== e.vec) begin
                        n_err++;
                        $display("FAIL key_pulse cycle %0d: got %b required %b", cyc, key_pulse, e.vec);
                    end
                    n_cmp++;
                    if (any_pulse !== (|e.vec)) begin
                        n_err++;
                        $display("FAIL any_pulse cycle %0d: got %b required %b", cyc, any_pulse, |e.vec);
                    end
                end
            end
            while (level_q.size() != 0 && level_q[0].cyc <= cyc) begin
                e = level_q.pop_front();
                n_cmp++;
                if (e.cyc != cyc) begin
                    n_err++;
                    $display("FAIL key_level_missed: check for cycle %0d reached at cycle %0d", e.cyc, cyc);
                end else if (key_level !== e.vec) begin
                    n_err++;
                    $display("FAIL key_level cycle %0d: got %b required %b", cyc, key_level, e.vec);
                end
            end
            if (done) begin
                while (pulse_q.size() != 0) begin
                    e = pulse_q.pop_front();
                    n_cmp++;
                    n_err++;
                    $display("FAIL missing_pulse: got none required %b at cycle %0d", e.vec, e.cyc);
                end
                while (level_q.size() != 0) begin
                    e = level_q.pop_front();
                    n_cmp++;
                    n_err++;
                    $display("FAIL missing_level_check: got none required %b at cycle %0d", e.vec, e.cyc);
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
                $finish;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of stimulus required finish before 100000 time units");
        $fatal(1);
    end

endmodule
